// File: rtl/fifo_cdc_pkg.sv
// ---------------------------------------------------------------------------
// fifo_cdc_pkg
//   Shared definitions for the write-side and read-side pointer blocks of the
//   asynchronous CDC FIFO.
//   - FIFO_ADDR_W : default address width (DEPTH = 2**FIFO_ADDR_W)
//   - ptr_t       : pointer type, one bit wider than the address so the MSB
//                   distinguishes full from empty
//   - bin2gray / gray2bin : pointer code conversions at the default width
// ---------------------------------------------------------------------------
package fifo_cdc_pkg;

  localparam int FIFO_ADDR_W = 3;

  typedef logic [FIFO_ADDR_W:0] ptr_t;

  // Binary to reflected Gray: adjacent counts differ in exactly one bit.
  function automatic ptr_t bin2gray(input ptr_t b);
    return b ^ (b >> 1);
  endfunction

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  function automatic ptr_t gray2bin(input ptr_t g);
    ptr_t b;
    b = g;
    for (int i = FIFO_ADDR_W - 1; i >= 0; i--) begin
      b[i] = b[i + 1] ^ g[i];
    end
    return b;
  endfunction

endpackage : fifo_cdc_pkg

// File: rtl/fifo_gray2bin.sv
// ---------------------------------------------------------------------------
// fifo_gray2bin
//   Parameterised, purely combinational Gray-to-binary converter
//   (XOR prefix from the MSB down). Shared by the write-side and read-side
//   pointer blocks.
//   Ports:
//     gray  in  W  Gray-coded value
//     bin   out W  binary equivalent
// ---------------------------------------------------------------------------
module fifo_gray2bin
  import fifo_cdc_pkg::*;
#(
  parameter int W = FIFO_ADDR_W + 1
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Bit i is the reduction XOR of gray[W-1:i]; no bit depends on another
  // output bit, so there is no combinational self-reference.
  always_comb begin
    bin = {W{1'b0}};
    for (int i = 0; i < W; i++) begin
      bin[i] = ^(gray >> i);
    end
  end

endmodule : fifo_gray2bin

// File: rtl/fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// fifo_wptr_full
//   Write-domain pointer and full-flag generator of the async CDC FIFO.
//   Keeps a binary write counter (RAM address) and a registered Gray copy that
//   crosses into the read domain. The full flag compares the next Gray pointer
//   against the synchronised read pointer, so full asserts on the very edge
//   that accepts the DEPTH-th outstanding write, and is released only after
//   the read pointer has crossed back (pessimistic, never optimistic).
//
//   Optional feature, enabled by defining FIFO_WPTR_ALMOST_FULL_EN:
//     registered fill level (wlevel) and almost_full flag. When the macro is
//     not defined both outputs are tied low and no Gray decoder is built; the
//     port list is identical in both builds.
//
//   Ports:
//     clk          in   1         write clock, all state on rising edge
//     rst          in   1         synchronous active-high reset
//     wr_en        in   1         producer write request
//     wq2_rptr     in   ADDR_W+1  Gray read pointer, already synchronised
//     wr_accept    out  1         wr_en & ~wfull (RAM write strobe)
//     waddr        out  ADDR_W    RAM write address
//     wptr         out  ADDR_W+1  registered Gray write pointer
//     wfull        out  1         registered full flag
//     overflow     out  1         sticky: write attempted while full
//     almost_full  out  1         registered almost-full flag (optional)
//     wlevel       out  ADDR_W+1  registered fill level 0..DEPTH (optional)
// ---------------------------------------------------------------------------
module fifo_wptr_full
  import fifo_cdc_pkg::*;
#(
  parameter int ADDR_W    = FIFO_ADDR_W,
  parameter int AF_MARGIN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W:0]   wq2_rptr,
  output logic              wr_accept,
  output logic [ADDR_W-1:0] waddr,
  output logic [ADDR_W:0]   wptr,
  output logic              wfull,
  output logic              overflow,
  output logic              almost_full,
  output logic [ADDR_W:0]   wlevel
);

  localparam logic [ADDR_W:0] PTR_ZERO = {(ADDR_W + 1){1'b0}};

  // Margin outside 1..DEPTH-1 would make almost_full meaningless.
  if (AF_MARGIN < 1 || AF_MARGIN > (1 << ADDR_W) - 1) begin : g_af_margin_illegal
    $error("fifo_wptr_full: AF_MARGIN out of range 1..DEPTH-1");
  end

  logic [ADDR_W:0] wbin_r;
  logic [ADDR_W:0] wptr_r;
  logic            wfull_r;
  logic            overflow_r;

  logic            inc_s;
  logic [ADDR_W:0] wbin_next_s;
  logic [ADDR_W:0] wgray_next_s;
  logic [ADDR_W:0] full_cmp_s;
  logic            wfull_next_s;

  // Next-pointer and full-detect logic.
  // Full when the next Gray pointer equals the read pointer with its two MSBs
  // inverted: that is exactly "one lap ahead" in Gray space.
  always_comb begin
    inc_s        = wr_en & ~wfull_r;
    wbin_next_s  = wbin_r + {{ADDR_W{1'b0}}, inc_s};
    wgray_next_s = wbin_next_s ^ (wbin_next_s >> 1);
    full_cmp_s   = {~wq2_rptr[ADDR_W:ADDR_W-1], wq2_rptr[ADDR_W-2:0]};
    wfull_next_s = (wgray_next_s == full_cmp_s);
  end

  // Pointer, full and sticky overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_r     <= PTR_ZERO;
      wptr_r     <= PTR_ZERO;
      wfull_r    <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      wbin_r  <= wbin_next_s;
      wptr_r  <= wgray_next_s;
      wfull_r <= wfull_next_s;
      if (wr_en && wfull_r) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  assign wr_accept = inc_s;
  assign waddr     = wbin_r[ADDR_W-1:0];
  // Driven straight from a flop so the pointer crossing never glitches.
  assign wptr      = wptr_r;
  assign wfull     = wfull_r;
  assign overflow  = overflow_r;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam int              DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W:0] AF_THRESH = (ADDR_W + 1)'(DEPTH - AF_MARGIN);

  logic [ADDR_W:0] rbin_s;
  logic [ADDR_W:0] level_next_s;
  logic            almost_full_r;
  logic [ADDR_W:0] wlevel_r;

  fifo_gray2bin #(
    .W (ADDR_W + 1)
  ) u_rptr_g2b (
    .gray (wq2_rptr),
    .bin  (rbin_s)
  );

  // Modulo subtraction yields 0..DEPTH because the pointers never drift
  // more than one lap apart.
  always_comb begin
    level_next_s = wbin_next_s - rbin_s;
  end

  // Fill level and almost-full registers, updated alongside wfull.
  always_ff @(posedge clk) begin
    if (rst) begin
      wlevel_r      <= PTR_ZERO;
      almost_full_r <= 1'b0;
    end else begin
      wlevel_r      <= level_next_s;
      almost_full_r <= (level_next_s >= AF_THRESH);
    end
  end

  assign wlevel      = wlevel_r;
  assign almost_full = almost_full_r;
`else
  assign wlevel      = PTR_ZERO;
  assign almost_full = 1'b0;
`endif

endmodule : fifo_wptr_full

// File: tb/tb_fifo_wptr_full.sv
// ---------------------------------------------------------------------------
// tb_fifo_wptr_full
//   Scoreboard bench for fifo_wptr_full (ADDR_W=3, DEPTH=8, AF_MARGIN=2).
//   The stimulus process drives one cycle at a time and pushes the expected
//   response; a monitor samples wr_accept/waddr before the edge and the
//   registered outputs just after it, and compares against the queue head.
// ---------------------------------------------------------------------------
module tb_fifo_wptr_full;

`ifdef FIFO_WPTR_ALMOST_FULL_EN
  localparam bit AF_EN = 1'b1;
`else
  localparam bit AF_EN = 1'b0;
`endif

  typedef struct {
    string      tag;
    logic       acc;
    int         waddr;   // -1 = not checked
    logic [3:0] wptr;
    logic       wfull;
    logic       ovf;
    logic       af;
    logic [3:0] lvl;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wq2_rptr = 4'b0000;
  logic       wr_accept;
  logic [2:0] waddr;
  logic [3:0] wptr;
  logic       wfull;
  logic       overflow;
  logic       almost_full;
  logic [3:0] wlevel;

  // Hand-written reflected Gray sequence for counts 0..15.
  logic [3:0] gray_tab [16] = '{
    4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
    4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000
  };

  exp_t q[$];
  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   push_cnt = 0;
  int   done_cnt = 0;

  fifo_wptr_full #(
    .ADDR_W    (3),
    .AF_MARGIN (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_en       (wr_en),
    .wq2_rptr    (wq2_rptr),
    .wr_accept   (wr_accept),
    .waddr       (waddr),
    .wptr        (wptr),
    .wfull       (wfull),
    .overflow    (overflow),
    .almost_full (almost_full),
    .wlevel      (wlevel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s %s: got %0h, expected %0h", tag, name, act, exp);
    end
  endtask

  // One stimulus cycle: drive inputs for the next edge and queue the response.
  task automatic step(input string tag, input logic r, input logic we, input logic [3:0] rp,
                      input logic acc, input int wa, input logic [3:0] wp, input logic wf,
                      input logic ov, input logic af, input logic [3:0] lv);
    exp_t e;
    @(posedge clk);
    #2;
    rst      = r;
    wr_en    = we;
    wq2_rptr = rp;
    e.tag   = tag;
    e.acc   = acc;
    e.waddr = wa;
    e.wptr  = wp;
    e.wfull = wf;
    e.ovf   = ov;
    e.af    = AF_EN ? af : 1'b0;
    e.lvl   = AF_EN ? lv : 4'd0;
    q.push_back(e);
    push_cnt++;
  endtask

  // Monitor: pre-edge combinational sample, post-edge registered sample.
  initial begin
    exp_t e;
    logic       acc_s;
    logic [2:0] waddr_s;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e       = q.pop_front();
        acc_s   = wr_accept;
        waddr_s = waddr;
        @(posedge clk);
        #1;
        check(e.tag, "wr_accept", int'(acc_s), int'(e.acc));
        if (e.waddr >= 0) begin
          check(e.tag, "waddr", int'(waddr_s), e.waddr);
        end
        check(e.tag, "wptr", int'(wptr), int'(e.wptr));
        check(e.tag, "wfull", int'(wfull), int'(e.wfull));
        check(e.tag, "overflow", int'(overflow), int'(e.ovf));
        check(e.tag, "almost_full", int'(almost_full), int'(e.af));
        check(e.tag, "wlevel", int'(wlevel), int'(e.lvl));
        done_cnt++;
      end
    end
  end

  initial begin
    int lvl;
    int rj;
    // Reset state
    step("reset0", 1'b1, 1'b0, 4'b0000, 1'b0, -1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);
    step("reset1", 1'b1, 1'b0, 4'b0000, 1'b0,  0, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // 1: fill from empty; full on the 8th accepting edge
    for (int k = 0; k < 8; k++) begin
      step("fill", 1'b0, 1'b1, 4'b0000, 1'b1, k, gray_tab[k + 1], (k == 7), 1'b0,
           (k + 1 >= 6), 4'(k + 1));
    end

    // 2: writes while full are refused, overflow sticks
    for (int k = 0; k < 3; k++) begin
      step("ovf", 1'b0, 1'b1, 4'b0000, 1'b0, 0, 4'b1100, 1'b1, 1'b1, 1'b1, 4'd8);
    end
    step("ovf_hold", 1'b0, 1'b0, 4'b0000, 1'b0, 0, 4'b1100, 1'b1, 1'b1, 1'b1, 4'd8);

    // 3: one read crosses back -> full releases, one write refills
    step("release", 1'b0, 1'b0, 4'b0001, 1'b0, 0, 4'b1100, 1'b0, 1'b1, 1'b1, 4'd7);
    step("refill",  1'b0, 1'b1, 4'b0001, 1'b1, 0, 4'b1101, 1'b1, 1'b1, 1'b1, 4'd8);

    // reset while full with wr_en high (refused write, reset wins)
    step("rst_full", 1'b1, 1'b1, 4'b0001, 1'b0, 1, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // 4: 20 writes, read pointer trailing 3 clk -> wrap, never full
    for (int j = 0; j < 20; j++) begin
      rj  = (j >= 3) ? (j - 3) : 0;
      lvl = j + 1 - rj;
      step("wrap", 1'b0, 1'b1, gray_tab[rj % 16], 1'b1, j % 8, gray_tab[(j + 1) % 16],
           1'b0, 1'b0, 1'b0, 4'(lvl));
    end

    // 5: mid-stream reset with wr_en high
    step("rst_mid", 1'b1, 1'b1, gray_tab[17 % 16], 1'b1, 4, 4'b0000, 1'b0, 1'b0, 1'b0, 4'd0);

    // 6: six writes with read pointer at 0 -> almost_full on the 6th edge
    for (int k = 0; k < 6; k++) begin
      step("af", 1'b0, 1'b1, 4'b0000, 1'b1, k, gray_tab[k + 1], 1'b0, 1'b0,
           (k == 5), 4'(k + 1));
    end
    step("idle", 1'b0, 1'b0, 4'b0000, 1'b0, 6, 4'b0101, 1'b0, 1'b0, 1'b1, 4'd6);

    // Drain the scoreboard with a bounded wait.
    for (int t = 0; t < 20 && done_cnt != push_cnt; t++) begin
      @(posedge clk);
    end
    #3;
    chk_cnt++;
    if (done_cnt == push_cnt) begin
      pass_cnt++;
    end else begin
      $display("FAIL drain: got %0d responses, expected %0d", done_cnt, push_cnt);
    end
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_fifo_wptr_full
